max_128b_frame_argmax: RTL and testbench
========================================

// Module: max_128b_frame_argmax
// PURPOSE
//  Sequential reducer downstream of the 4-lane 128-bit max stage. Consumes one
//  (max value, winning lane) pair per accepted beat and tracks the frame-wide
//  maximum, its lane and its sample position. Emits one result per frame over
//  a valid/ready handshake. The frame ends after FRAME_LEN beats or at an
//  early in_last.
// PARAMETERS
//  WIDTH      128  data width; equals the max stage value width
//  FRAME_LEN  16   beats per full frame; >=2, need not be a power of two
//  POS_W      $clog2(FRAME_LEN)  localparam, width of the sample position
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous reset, active-high
//  in_valid   in   1        upstream beat valid
//  in_ready   out  1        block accepts a beat this cycle
//  in_max     in   WIDTH    max value from the max stage (its out0)
//  in_lane    in   2        winning lane from the max stage (its out1)
//  in_last    in   1        marks the accepted beat as the frame's last (early end)
//  out_valid  out  1        frame result valid
//  out_ready  in   1        downstream takes the result
//  out_max    out  WIDTH    largest in_max of the frame
//  out_lane   out  2        in_lane paired with out_max
//  out_pos    out  POS_W    beat index (0-based) of out_max within the frame
//  out_count  out  POS_W+1  beats in the frame (1..FRAME_LEN)
// BEHAVIOUR
//  - Reset (async, rst=1): state=ACCUM, cnt=0, out_valid=0.
//    out_max, out_lane, out_pos and out_count are all 0.
//    in_ready = (state==ACCUM), so in_ready=1 out of reset.
//    Beats presented while rst=1 are discarded.
//  - Accept: in_valid & in_ready at a rising clk edge.
//  - FSM ACCUM:
//    - First beat (cnt==0): unconditionally loads best=in_max, lane=in_lane, pos=0.
//    - Later beats: update only if in_max > best (unsigned, strict).
//      Ties keep the earliest beat.
//    - Each accept: cnt <= cnt+1.
//    - If the accepted beat has in_last=1 or cnt==FRAME_LEN-1:
//      - next state HOLD; out_count = cnt+1.
//      - out_* reflect this beat's contribution.
//      - out_valid=1 on the following cycle. Latency: 1 clk from last accept.
//  - FSM HOLD:
//    - in_ready=0, out_valid=1.
//    - out_* stable until out_ready=1; upstream beats stall (not dropped).
//    - On out_valid & out_ready: next state ACCUM, cnt=0, out_valid=0.
//      out_* keep their last values.
//    - Earliest next-frame accept is the cycle after the handshake.
//    - Minimum cost is one bubble per frame.
//  - Widths:
//    - Comparison is full WIDTH unsigned; all-ones is a legal maximum.
//    - cnt never exceeds FRAME_LEN-1, so there is no wrap.
//    - out_count=FRAME_LEN fits in POS_W+1 bits.
//  - in_last on the first beat gives out_count=1, out_pos=0.
//  - in_last is ignored when not accepted.
//  - in_max and in_lane are treated as one atomic pair; the lane is never
//    updated without its value.
//  - Reset mid-frame or mid-HOLD:
//    - Partial frame is discarded; no result is emitted for it.
//    - Next accepted beat after reset release starts a fresh frame at pos 0.
// TESTING (bench uses FRAME_LEN=4)
//  1 Hold rst=1 for 3 clk with in_valid=1:
//    -> out_valid=0, out_max=0, out_lane=0, out_count=0, in_ready=1.
//    -> No beat is counted after release.
//  2 Beats (5,L0),(9,L1),(3,L2),(7,L3), out_ready=1:
//    -> 1 clk after 4th accept: out_valid=1, out_max=9, out_lane=1, out_pos=1,
//       out_count=4.
//    -> in_ready=0 for exactly 1 cycle.
//  3 Beats (8,L2),(8,L0),(2,L1),(8,L3):
//    -> out_max=8, out_lane=2, out_pos=0 (tie keeps earliest).
//  4 Beats (1,L0),(2^128-1,L3) with in_last on beat 2:
//    -> out_max=all ones, out_lane=3, out_pos=1, out_count=2.
//    -> Next frame starts at pos 0.
//  5 Frame ends with out_ready=0 for 5 cycles while in_valid=1:
//    -> out_* constant, in_ready=0, no beats consumed.
//    -> out_ready=1: handshake, next cycle in_ready=1, new frame best is
//       loaded from its first beat.
//  6 Assert rst after 2 of 4 beats, release, send (4,L1),(6,L2),(5,L0),(1,L3):
//    -> out_max=6, out_lane=2, out_pos=1, out_count=4.
//    -> Pre-reset beats are not included.

Source files
------------

// File: rtl/max_128b_frame_argmax.sv
`default_nettype none
// ============================================================================
// Module   : max_128b_frame_argmax
// Brief    : Frame-wide argmax over (max value, lane) beats with a one-result
//            per frame valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module max_128b_frame_argmax #(
  parameter int  WIDTH     = 128,
  parameter int  FRAME_LEN = 16,
  localparam int POS_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_max,
  input  logic [1:0]       in_lane,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [1:0]       out_lane,
  output logic [POS_W-1:0] out_pos,
  output logic [POS_W:0]   out_count
);

  localparam logic [0:0]       c_st_accum = 1'b0;
  localparam logic [0:0]       c_st_hold  = 1'b1;
  localparam logic [POS_W-1:0] c_last_idx = POS_W'(FRAME_LEN - 1);

  logic [0:0]       r_state;
  logic [POS_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_best;
  logic [1:0]       r_lane;
  logic [POS_W-1:0] r_pos;
  logic [WIDTH-1:0] r_out_max;
  logic [1:0]       r_out_lane;
  logic [POS_W-1:0] r_out_pos;
  logic [POS_W:0]   r_out_count;

  logic             w_accept;
  logic             w_take;
  logic             w_end;
  logic [WIDTH-1:0] w_best;
  logic [1:0]       w_lane;
  logic [POS_W-1:0] w_pos;
  logic [POS_W:0]   w_count;

  assign in_ready  = (r_state == c_st_accum);
  assign out_valid = (r_state == c_st_hold);
  assign out_max   = r_out_max;
  assign out_lane  = r_out_lane;
  assign out_pos   = r_out_pos;
  assign out_count = r_out_count;

  assign w_accept = in_valid & in_ready;
  // Strict compare keeps the earliest beat on ties; the first beat always loads.
  assign w_take   = (r_cnt == '0) | (in_max > r_best);
  assign w_best   = w_take ? in_max  : r_best;
  assign w_lane   = w_take ? in_lane : r_lane;
  assign w_pos    = w_take ? r_cnt   : r_pos;
  assign w_end    = in_last | (r_cnt == c_last_idx);
  assign w_count  = {1'b0, r_cnt} + (POS_W+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_st_accum;
      r_cnt       <= '0;
      r_best      <= '0;
      r_lane      <= '0;
      r_pos       <= '0;
      r_out_max   <= '0;
      r_out_lane  <= '0;
      r_out_pos   <= '0;
      r_out_count <= '0;
    end else if (r_state == c_st_accum) begin
      if (w_accept) begin
        r_best <= w_best;
        r_lane <= w_lane;
        r_pos  <= w_pos;
        if (w_end) begin
          // Results are captured including this beat; cnt restarts for the next frame.
          r_state     <= c_st_hold;
          r_cnt       <= '0;
          r_out_max   <= w_best;
          r_out_lane  <= w_lane;
          r_out_pos   <= w_pos;
          r_out_count <= w_count;
        end else begin
          r_cnt <= r_cnt + POS_W'(1);
        end
      end
    end else begin
      if (out_ready) begin
        r_state <= c_st_accum;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_max_128b_frame_argmax.sv
`default_nettype none
// ============================================================================
// Module   : tb_max_128b_frame_argmax
// Brief    : Self-checking bench: table vectors, directed corners, random frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_max_128b_frame_argmax;

  localparam int WIDTH     = 128;
  localparam int FRAME_LEN = 4;
  localparam int POS_W     = $clog2(FRAME_LEN);

  typedef logic [WIDTH-1:0] val_t;

  typedef struct {
    int                     n;
    bit                     last;
    logic [3:0][WIDTH-1:0]  v;
    logic [3:0][1:0]        l;
    val_t                   emax;
    logic [1:0]             elane;
    int                     epos;
    int                     ecount;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_max;
  logic [1:0]       in_lane;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [1:0]       out_lane;
  logic [POS_W-1:0] out_pos;
  logic [POS_W:0]   out_count;

  int nchecks = 0;
  int nerrors = 0;

  max_128b_frame_argmax #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_max    (in_max),
    .in_lane   (in_lane),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_lane  (out_lane),
    .out_pos   (out_pos),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic val_t rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Presents one beat from a negedge and returns at the negedge after it is taken.
  task automatic put_beat(input val_t v, input logic [1:0] l, input logic last);
    int cyc = 0;
    in_valid = 1'b1;
    in_max   = v;
    in_lane  = l;
    in_last  = last;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) begin
      nchecks++;
      nerrors++;
      $display("FAIL beat_wait: got in_ready=0 expected in_ready=1 within 20 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0][WIDTH-1:0] v, input logic [3:0][1:0] l,
                            input int n, input bit last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_max   = rnd128();
        in_last  = 1'b1;
        @(negedge clk);
        in_last  = 1'b0;
      end
      put_beat(v[i], l[i], last && (i == n - 1));
    end
  endtask

  // Called at the negedge one clock after the final accept of a frame.
  task automatic get_result(input string nm, input val_t emax, input logic [1:0] elane,
                            input int epos, input int ecount, input int stall);
    check({nm, " out_valid"}, out_valid, 1);
    check({nm, " in_ready"},  in_ready,  0);
    check({nm, " out_max"},   out_max,   emax);
    check({nm, " out_lane"},  out_lane,  elane);
    check({nm, " out_pos"},   out_pos,   epos[POS_W-1:0]);
    check({nm, " out_count"}, out_count, ecount[POS_W:0]);
    if (stall > 0) begin
      out_ready = 1'b0;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        check({nm, " stall out_valid"}, out_valid, 1);
        check({nm, " stall in_ready"},  in_ready,  0);
        check({nm, " stall out_max"},   out_max,   emax);
        check({nm, " stall out_pos"},   out_pos,   epos[POS_W-1:0]);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    check({nm, " post out_valid"}, out_valid, 0);
    check({nm, " post in_ready"},  in_ready,  1);
    check({nm, " post out_max"},   out_max,   emax);
  endtask

  // Reference: the frame result is the largest value, reported at its first occurrence.
  task automatic ref_model(input logic [3:0][WIDTH-1:0] v, input logic [3:0][1:0] l, input int n,
                           output val_t mx, output logic [1:0] ln, output int pos);
    mx = v[0];
    for (int i = 1; i < n; i++) if (v[i] > mx) mx = v[i];
    pos = 0;
    for (int i = n - 1; i >= 0; i--) if (v[i] == mx) pos = i;
    ln = l[pos];
  endtask

  vec_t                  tbl[3];
  logic [3:0][WIDTH-1:0] rv;
  logic [3:0][1:0]       rl;
  val_t                  emx;
  logic [1:0]            eln;
  int                    eps;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_max    = 77;
    in_lane   = 2'd3;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset held with beats offered: none may be counted.
    repeat (3) @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst out_max",   out_max,   0);
    check("rst out_lane",  out_lane,  0);
    check("rst out_count", out_count, 0);
    check("rst in_ready",  in_ready,  1);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    tbl[0] = '{n: 4, last: 1'b0, v: {val_t'(7), val_t'(3), val_t'(9), val_t'(5)},
               l: {2'd3, 2'd2, 2'd1, 2'd0}, emax: 9, elane: 2'd1, epos: 1, ecount: 4};
    tbl[1] = '{n: 2, last: 1'b1, v: {val_t'(0), val_t'(0), {WIDTH{1'b1}}, val_t'(1)},
               l: {2'd0, 2'd0, 2'd3, 2'd0}, emax: {WIDTH{1'b1}}, elane: 2'd3, epos: 1, ecount: 2};
    tbl[2] = '{n: 4, last: 1'b0, v: {val_t'(8), val_t'(2), val_t'(8), val_t'(8)},
               l: {2'd3, 2'd1, 2'd0, 2'd2}, emax: 8, elane: 2'd2, epos: 0, ecount: 4};
    for (int t = 0; t < 3; t++) begin
      send_frame(tbl[t].v, tbl[t].l, tbl[t].n, tbl[t].last, 1'b0);
      get_result($sformatf("tbl%0d", t), tbl[t].emax, tbl[t].elane, tbl[t].epos, tbl[t].ecount, 0);
    end

    // Single-beat frame closed by in_last.
    put_beat(val_t'(42), 2'd2, 1'b1);
    get_result("single", 42, 2'd2, 0, 1, 0);

    // Backpressure with upstream offering a beat throughout the stall.
    send_frame({val_t'(20), val_t'(15), val_t'(20), val_t'(10)}, {2'd3, 2'd2, 2'd0, 2'd1}, 4, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_max   = 99;
    in_lane  = 2'd3;
    in_last  = 1'b0;
    get_result("stall", 20, 2'd0, 1, 4, 5);
    @(negedge clk);
    in_valid = 1'b0;
    put_beat(val_t'(3), 2'd0, 1'b1);
    get_result("after_stall", 99, 2'd3, 0, 2, 0);

    // Reset mid-frame: the partial frame is discarded.
    put_beat(val_t'(100), 2'd1, 1'b0);
    put_beat(val_t'(200), 2'd2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst out_valid", out_valid, 0);
    send_frame({val_t'(1), val_t'(5), val_t'(6), val_t'(4)}, {2'd3, 2'd0, 2'd2, 2'd1}, 4, 1'b0, 1'b0);
    get_result("midrst", 6, 2'd2, 1, 4, 0);

    // Reset while holding a result.
    out_ready = 1'b0;
    send_frame({val_t'(11), val_t'(12), val_t'(13), val_t'(14)}, {2'd0, 2'd1, 2'd2, 2'd3}, 4, 1'b0, 1'b0);
    check("holdrst pre out_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    check("holdrst out_valid", out_valid, 0);
    check("holdrst out_max",   out_max,   0);
    check("holdrst in_ready",  in_ready,  1);

    // Random frames against the reference model.
    for (int f = 0; f < 40; f++) begin
      int n;
      bit last;
      int mode;
      n    = $urandom_range(1, FRAME_LEN);
      last = (n < FRAME_LEN) ? 1'b1 : 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 4; i++) begin
        rv[i] = (mode == 0) ? val_t'($urandom_range(0, 3)) :
                (mode == 1) ? rnd128() :
                ($urandom_range(0, 1) ? {WIDTH{1'b1}} : val_t'($urandom_range(0, 3)));
        rl[i] = 2'($urandom_range(0, 3));
      end
      ref_model(rv, rl, n, emx, eln, eps);
      send_frame(rv, rl, n, last, 1'b1);
      get_result($sformatf("rnd%0d", f), emx, eln, eps, n, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
`default_nettype wire
